seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//   Scan controller for the 8-digit multiplexed 7-segment display (active-low anodes/cathodes).
//   Sequences one digit at a time with an inter-digit blanking gap and decodes hex nibbles to segments.
//   Applies per-digit enable and decimal-point masks.
//   Accepts new display content through a valid/ready port and commits it only at frame boundaries, so a frame never mixes old and new data.
//   Sits between the CPU debug/IO logic and the board display pins.
// PARAMETERS
//   TICK_DIV   50000  clk cycles each digit is lit (SHOW slot); legal range >= 2
//   BLANK_GAP  2      clk cycles all anodes are off between digits (anti-ghosting); 0 = no gap
// PORTS
//   clk         in   1   system clock; all logic on posedge
//   rst         in   1   synchronous, active-high reset
//   upd_valid   in   1   update request; upd_data/upd_mask/upd_dp are valid while high
//   upd_ready   out  1   controller can accept an update this cycle
//   upd_data    in   32  8 hex nibbles; nibble i = data[4i+3:4i] drives digit i (digit 0 = rightmost)
//   upd_mask    in   8   bit i = 1 enables digit i
//   upd_dp      in   8   bit i = 1 lights decimal point of digit i
//   an          out  8   anodes, active low; an[i] = digit i
//   seg         out  7   cathodes {g,f,e,d,c,b,a}, active low
//   dp          out  1   decimal point, active low
//   frame_done  out  1   one-cycle pulse when the scan wraps from digit 7 to digit 0
// BEHAVIOUR
//   Reset (rst=1 at a posedge), effective next cycle:
//     an=8'hFF, seg=7'h7F, dp=1, frame_done=0, upd_ready=1
//     idx=0, state=SHOW, tick=0
//     active data=0, mask=0, dp mask=0; staging cleared; pending=0
//   Reset mid-frame or with an update pending discards everything; no update is committed.
//   Internal state
//     idx 3b: current digit
//     tick: counts 0..TICK_DIV-1 in SHOW, 0..BLANK_GAP-1 in BLANK
//     FSM: SHOW, BLANK
//   SHOW:
//     Lasts exactly TICK_DIV cycles.
//     an = ~(8'b1<<idx) if mask[idx], else 8'hFF.
//     seg = decode(nibble idx).
//     dp = ~dpmask[idx] if mask[idx], else 1.
//     On the last cycle: -> BLANK, or, if BLANK_GAP==0, -> SHOW with idx+1.
//   BLANK:
//     Lasts BLANK_GAP cycles; an=8'hFF, seg=7'h7F, dp=1.
//     On the last cycle: idx <= idx+1 (7 wraps to 0); -> SHOW.
//   Frame boundary: the cycle in which idx advances 7->0.
//     frame_done=1 during that cycle only.
//     If pending was 1 at the start of that cycle, copy staging to active and clear pending.
//     Frame period = 8*(TICK_DIV+BLANK_GAP) cycles.
//   an/seg/dp are registered: they reflect FSM/idx state with exactly 1 cycle latency.
//     No combinational path from any input to any output.
//   Handshake
//     upd_ready = ~pending (registered).
//     Transfer occurs when upd_valid & upd_ready; staging <= {data,mask,dp}; pending <= 1.
//     upd_ready drops on the next cycle.
//     upd_valid with upd_ready=0 is ignored; the requester must hold its data until accepted.
//     Only one update is held; there is no queue beyond the staging register.
//   Simultaneous transfer and frame boundary (pending=0 at start):
//     the transfer loads staging and is committed at the NEXT boundary, not this one.
//   Decode: standard hex glyphs, active low.
//     0=1000000, 1=1111001, 2=0100100, 3=0110000
//     4=0011001, 5=0010010, 6=0000010, 7=1111000
//     8=0000000, 9=0010000, A=0001000, b=0000011
//     C=1000110, d=0100001, E=0000110, F=0001110
// TESTING  (TICK_DIV=4, BLANK_GAP=2 unless stated)
//   1. rst high 3 cycles, then low
//      -> an=FF, seg=7F, dp=1, upd_ready=1.
//      -> First frame: an stays FF for all 48 cycles (mask=0); frame_done pulses every 48 cycles.
//   2. Send data=32'h0123ABCD, mask=FF, dp=01 at reset+5
//      -> visible from the first boundary: an=FE,seg=0100001,dp=0 for 4 cycles;
//         then FF for 2 cycles; then an=FD,seg=1000110,dp=1; ...
//         digit 7: an=7F, seg=1000000.
//   3. Send data=32'h12345678, mask=0F
//      -> digits 0..3 show 8,7,6,5; an=FF throughout the slots for digits 4..7.
//   4. Send A, then assert B while pending
//      -> upd_ready=0 and B is not taken.
//      -> A appears at the boundary; B is accepted the cycle after upd_ready returns;
//         B appears one frame later. No frame mixes A and B nibbles.
//   5. Transfer in the frame_done cycle with pending=0
//      -> display is unchanged for that frame; the new data appears at the following boundary.
//   6. rst asserted mid-frame with an update pending
//      -> next cycle: an=FF, upd_ready=1; after release the old staged data is never displayed.
//      Also run with BLANK_GAP=0: an goes directly FE->FD with no FF cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-segment scanner with blanking gap and frame-aligned updates
module seg7_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_data,
  input  logic [7:0]  upd_mask,
  input  logic [7:0]  upd_dp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int TW = $clog2((TICK_DIV > BLANK_GAP ? TICK_DIV : BLANK_GAP) + 1);
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {SHOW, BLANK} state_t;
  state_t      state;
  logic [2:0]  idx;
  logic [TW-1:0] tick;
  logic [31:0] data, stg_data;
  logic [7:0]  mask, dpm, stg_mask, stg_dp;
  logic        pending;
  logic        last_show, last_blank, adv;
  logic [3:0]  nib;
  assign last_show  = state == SHOW && tick == TW'(TICK_DIV - 1);
  assign last_blank = state == BLANK && tick == TW'(BLANK_GAP == 0 ? 0 : BLANK_GAP - 1);
  assign adv        = BLANK_GAP == 0 ? last_show : last_blank;
  assign frame_done = adv && idx == 3'd7;
  assign upd_ready  = ~pending;
  assign nib        = data[{idx, 2'b00} +: 4];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHOW;
      idx      <= '0;
      tick     <= '0;
      an       <= 8'hFF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
      data     <= '0;
      mask     <= '0;
      dpm      <= '0;
      stg_data <= '0;
      stg_mask <= '0;
      stg_dp   <= '0;
      pending  <= 1'b0;
    end else begin
      an    <= (state == SHOW && mask[idx]) ? ~(8'b1 << idx) : 8'hFF;
      seg   <= state == SHOW ? GLYPH[nib] : 7'h7F;
      dp    <= ~(state == SHOW && mask[idx] && dpm[idx]);
      tick  <= (last_show || last_blank) ? '0 : tick + 1'b1;
      state <= (last_show && BLANK_GAP != 0) ? BLANK : last_blank ? SHOW : state;
      if (adv) idx <= idx + 3'd1;
      // Commit only a pending update so a transfer in the boundary cycle waits a whole frame
      if (frame_done && pending) begin
        data    <= stg_data;
        mask    <= stg_mask;
        dpm     <= stg_dp;
        pending <= 1'b0;
      end else if (upd_valid && !pending) begin
        stg_data <= upd_data;
        stg_mask <= upd_mask;
        stg_dp   <= upd_dp;
        pending  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random updates/resets on two geometries checked against a frame-position model
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_data = '0;
  logic [7:0]  upd_mask = '0, upd_dp = '0;
  logic        rdy0, rdy1, dp0, dp1, fd0, fd1;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  int tests = 0, fails = 0;
  int td [2] = '{4, 3};
  int bg [2] = '{2, 0};
  int t [2];
  logic [31:0] a_data [2], s_data [2];
  logic [7:0]  a_mask [2], a_dp [2], s_mask [2], s_dp [2], e_an [2];
  logic [6:0]  e_seg [2];
  logic        e_dp [2], pend [2];
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.TICK_DIV(4), .BLANK_GAP(2)) u0 (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(rdy0), .upd_data(upd_data),
    .upd_mask(upd_mask), .upd_dp(upd_dp), .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0));
  seg7_scan_ctrl #(.TICK_DIV(3), .BLANK_GAP(0)) u1 (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(rdy1), .upd_data(upd_data),
    .upd_mask(upd_mask), .upd_dp(upd_dp), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1));
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010; 4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, t[0]);
    end
  endtask
  task automatic check_inst(input int k, input logic [7:0] a, input logic [6:0] s, input logic d,
                            input logic f, input logic r);
    int per;
    per = 8 * (td[k] + bg[k]);
    check($sformatf("an%0d", k), 32'(a), 32'(e_an[k]));
    check($sformatf("seg%0d", k), 32'(s), 32'(e_seg[k]));
    check($sformatf("dp%0d", k), 32'(d), 32'(e_dp[k]));
    check($sformatf("frame_done%0d", k), 32'(f), 32'(t[k] % per == per - 1));
    check($sformatf("upd_ready%0d", k), 32'(r), 32'(!pend[k]));
  endtask
  // Advance model k by one clock: outputs follow the scan position of the cycle just ending
  task automatic step(input int k, input bit rs, input bit v);
    int len, per, pos, dig;
    bit show;
    if (rs) begin
      t[k] = 0; e_an[k] = 8'hFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; pend[k] = 1'b0;
      a_data[k] = '0; a_mask[k] = '0; a_dp[k] = '0; s_data[k] = '0; s_mask[k] = '0; s_dp[k] = '0;
      return;
    end
    len  = td[k] + bg[k];
    per  = 8 * len;
    pos  = t[k] % per;
    dig  = pos / len;
    show = (pos % len) < td[k];
    e_an[k]  = (show && a_mask[k][dig]) ? ~(8'd1 << dig) : 8'hFF;
    e_seg[k] = show ? glyph(a_data[k][dig*4 +: 4]) : 7'h7F;
    e_dp[k]  = (show && a_mask[k][dig]) ? ~a_dp[k][dig] : 1'b1;
    if (pos == per - 1 && pend[k]) begin
      a_data[k] = s_data[k]; a_mask[k] = s_mask[k]; a_dp[k] = s_dp[k]; pend[k] = 1'b0;
    end else if (v && !pend[k]) begin
      s_data[k] = upd_data; s_mask[k] = upd_mask; s_dp[k] = upd_dp; pend[k] = 1'b1;
    end
    t[k]++;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    for (int c = 0; c < 6000; c++) begin
      bit rs;
      @(negedge clk);
      check_inst(0, an0, seg0, dp0, fd0, rdy0);
      check_inst(1, an1, seg1, dp1, fd1, rdy1);
      rs = c > 50 && $urandom_range(0, 499) == 0;
      rst = rs;
      upd_valid = $urandom_range(0, 7) == 0;
      upd_data  = $urandom;
      upd_mask  = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
      upd_dp    = 8'($urandom);
      step(0, rs, upd_valid);
      step(1, rs, upd_valid);
      @(posedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
